// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised interrupt controller with edge/level sources, enable mask and REQ/SERVICE handshake.
// Optional IRQ_SYNC_EN adds a two-flop input synchronizer ahead of src_q.
module irq_ctrl #(
    parameter int NUM_SRC = 4,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               interrupter,
    output logic [2:0]         irq_id,
    output logic [NUM_SRC-1:0] pending
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t state, nxt;
    logic [NUM_SRC-1:0] src_in, src_q, src_d, pend_e, enable, elig, sel, ack_clr;
    logic [2:0] win;
    logic any, cur_ok, ack_ok;
`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1, sync2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
        end
    end
    assign src_in = sync2;
`else
    assign src_in = irq_src;
`endif
    assign pending = (pend_e & EDGE_MASK) | (src_q & ~EDGE_MASK);
    assign elig    = pending & enable;
    assign any     = |elig;
    assign ack_ok  = int_ack && state == REQ;
    assign ack_clr = sel & {NUM_SRC{ack_ok}};
    assign cur_ok  = |(elig & sel);
    // Scan downward so the lowest eligible index is the last one written.
    always_comb begin
        win = '0;
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) win = 3'(i);
            sel[i] = irq_id == 3'(i);
        end
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = any ? REQ : IDLE;
            REQ:     nxt = int_ack ? SERVICE : (cur_ok ? REQ : IDLE);
            SERVICE: nxt = int_done ? IDLE : SERVICE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            interrupter <= 1'b0;
            irq_id      <= '0;
        end else begin
            state       <= nxt;
            interrupter <= nxt == REQ;
            if (state == IDLE && any) irq_id <= win;
        end
    end
    // A fresh rise is OR-ed in after the ack clear so set wins a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q  <= '0;
            src_d  <= '0;
            pend_e <= '0;
            enable <= '1;
        end else begin
            src_q  <= src_in;
            src_d  <= src_q;
            pend_e <= (pend_e & ~ack_clr) | (src_q & ~src_d);
            if (en_we) enable <= en_wdata;
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven and directed checks of irq_ctrl (default build) plus a level-source instance.
`timescale 1ns/1ps
module tb_irq_ctrl;
    logic clk = 0, rst = 0;
    logic [3:0] irq_src = 0, en_wdata = 0, pending;
    logic en_we = 0, int_ack = 0, int_done = 0, interrupter;
    logic [2:0] irq_id;
    logic [3:0] src2 = 0, pending2;
    logic ack2 = 0, done2 = 0, int2;
    logic [2:0] id2;
    int total = 0, bad = 0;

    irq_ctrl dut (.clk(clk), .rst(rst), .irq_src(irq_src), .en_we(en_we), .en_wdata(en_wdata),
                  .int_ack(int_ack), .int_done(int_done), .interrupter(interrupter),
                  .irq_id(irq_id), .pending(pending));
    irq_ctrl #(.NUM_SRC(4), .EDGE_MASK(4'b0111)) dut2 (.clk(clk), .rst(rst), .irq_src(src2),
                  .en_we(1'b0), .en_wdata(4'b0000), .int_ack(ack2), .int_done(done2),
                  .interrupter(int2), .irq_id(id2), .pending(pending2));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] src;
        logic       ack;
        logic       done;
        logic       exp_int;
        logic [2:0] exp_id;
        logic [3:0] exp_pend;
    } vec_t;
    vec_t v[24];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        v[0]  = '{4'b0110, 0, 0, 0, 3'd0, 4'b0000};
        v[1]  = '{4'b0000, 0, 0, 0, 3'd0, 4'b0110};
        v[2]  = '{4'b0000, 0, 0, 1, 3'd1, 4'b0110};
        v[3]  = '{4'b0000, 1, 0, 0, 3'd1, 4'b0100};
        v[4]  = '{4'b1000, 0, 0, 0, 3'd1, 4'b0100};
        v[5]  = '{4'b0000, 0, 0, 0, 3'd1, 4'b1100};
        v[6]  = '{4'b0000, 0, 0, 0, 3'd1, 4'b1100};
        v[7]  = '{4'b0000, 0, 1, 0, 3'd1, 4'b1100};
        v[8]  = '{4'b0000, 0, 0, 1, 3'd2, 4'b1100};
        v[9]  = '{4'b0000, 1, 0, 0, 3'd2, 4'b1000};
        v[10] = '{4'b0000, 0, 1, 0, 3'd2, 4'b1000};
        v[11] = '{4'b0000, 0, 0, 1, 3'd3, 4'b1000};
        v[12] = '{4'b0000, 1, 0, 0, 3'd3, 4'b0000};
        v[13] = '{4'b0000, 0, 1, 0, 3'd3, 4'b0000};
        v[14] = '{4'b0001, 0, 0, 0, 3'd3, 4'b0000};
        v[15] = '{4'b0000, 0, 0, 0, 3'd3, 4'b0001};
        v[16] = '{4'b0000, 0, 0, 1, 3'd0, 4'b0001};
        v[17] = '{4'b0000, 1, 0, 0, 3'd0, 4'b0000};
        v[18] = '{4'b1000, 0, 0, 0, 3'd0, 4'b0000};
        v[19] = '{4'b0000, 0, 0, 0, 3'd0, 4'b1000};
        v[20] = '{4'b0000, 0, 1, 0, 3'd0, 4'b1000};
        v[21] = '{4'b0000, 0, 0, 1, 3'd3, 4'b1000};
        v[22] = '{4'b0000, 1, 0, 0, 3'd3, 4'b0000};
        v[23] = '{4'b0000, 0, 1, 0, 3'd3, 4'b0000};

        #12;
        chk("rst_int", 8'(interrupter), 8'h0);
        chk("rst_id", 8'(irq_id), 8'h0);
        chk("rst_pend", 8'(pending), 8'h0);
        @(negedge clk) rst = 1;
        tick;

        // sub-cycle pulse straddling one rising edge
        @(negedge clk);
        #4.65 irq_src[0] = 1;
        #0.7  irq_src[0] = 0;
        #0.65;
        tick;
        chk("pulse_e1_int", 8'(interrupter), 8'h0);
        chk("pulse_e1_pend", 8'(pending), 8'h01);
        tick;
        chk("pulse_e2_int", 8'(interrupter), 8'h1);
        chk("pulse_e2_id", 8'(irq_id), 8'h0);
        int_ack = 1;
        tick;
        int_ack = 0;
        chk("pulse_ack_pend", 8'(pending), 8'h0);
        chk("pulse_ack_int", 8'(interrupter), 8'h0);
        int_done = 1;
        tick;
        int_done = 0;
        chk("pulse_done_int", 8'(interrupter), 8'h0);

        for (int i = 0; i < 24; i++) begin
            irq_src  = v[i].src;
            int_ack  = v[i].ack;
            int_done = v[i].done;
            tick;
            chk($sformatf("vec%0d_int", i), 8'(interrupter), 8'(v[i].exp_int));
            chk($sformatf("vec%0d_id", i), 8'(irq_id), 8'(v[i].exp_id));
            chk($sformatf("vec%0d_pend", i), 8'(pending), 8'(v[i].exp_pend));
        end
        irq_src = 0; int_ack = 0; int_done = 0;

        // masked source stays pending until re-enabled
        en_we = 1; en_wdata = 4'b1110;
        tick;
        en_we = 0;
        irq_src = 4'b0001;
        tick;
        irq_src = 0;
        tick;
        tick;
        tick;
        chk("mask_int", 8'(interrupter), 8'h0);
        chk("mask_pend", 8'(pending), 8'h01);
        en_we = 1; en_wdata = 4'b1111;
        tick;
        en_we = 0;
        chk("unmask_same_cycle_int", 8'(interrupter), 8'h0);
        tick;
        chk("unmask_int", 8'(interrupter), 8'h1);
        chk("unmask_id", 8'(irq_id), 8'h0);
        int_ack = 1;
        tick;
        int_ack = 0;
        int_done = 1;
        tick;
        int_done = 0;
        chk("unmask_clean_pend", 8'(pending), 8'h0);

        // asynchronous reset while a request is up
        irq_src = 4'b0010;
        tick;
        irq_src = 0;
        tick;
        tick;
        chk("prerst_int", 8'(interrupter), 8'h1);
        #2 rst = 0;
        #1;
        chk("async_rst_int", 8'(interrupter), 8'h0);
        chk("async_rst_pend", 8'(pending), 8'h0);
        chk("async_rst_id", 8'(irq_id), 8'h0);
        @(negedge clk) rst = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("postrst%0d_int", i), 8'(interrupter), 8'h0);
            chk($sformatf("postrst%0d_pend", i), 8'(pending), 8'h0);
        end

        // level source 3 on the second instance
        src2 = 4'b1000;
        tick;
        chk("lvl_pend", 8'(pending2), 8'h08);
        chk("lvl_int0", 8'(int2), 8'h0);
        tick;
        chk("lvl_req_int", 8'(int2), 8'h1);
        chk("lvl_req_id", 8'(id2), 8'h3);
        ack2 = 1;
        tick;
        ack2 = 0;
        chk("lvl_ack_int", 8'(int2), 8'h0);
        chk("lvl_ack_pend", 8'(pending2), 8'h08);
        done2 = 1;
        tick;
        done2 = 0;
        chk("lvl_done_int", 8'(int2), 8'h0);
        tick;
        chk("lvl_rereq_int", 8'(int2), 8'h1);
        chk("lvl_rereq_id", 8'(id2), 8'h3);
        src2 = 0;
        tick;
        chk("lvl_drop_pend", 8'(pending2), 8'h0);
        tick;
        chk("lvl_drop_int", 8'(int2), 8'h0);
        tick;
        chk("lvl_drop_stay", 8'(int2), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
